// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared constants and helpers for the register-file write-side controller.
// Holds the register width/count that decode, execute and the cell array agree on.
package regfile_wb_ctrl_pkg;

    localparam int LEN_REG    = 32;
    localparam int NUM_REG    = 16;
    localparam int IDX_W      = $clog2(NUM_REG);
    localparam int FIFO_DEPTH = 4;

    typedef enum logic {
        UNIT0 = 1'b0,
        UNIT1 = 1'b1
    } unit_t;

    // Round-robin pick: on a tie the unit not granted last wins.
    function automatic unit_t rr_pick(input logic v0, input logic v1, input unit_t last);
        if (v0 && v1) begin
            return (last == UNIT1) ? UNIT0 : UNIT1;
        end else if (v1) begin
            return UNIT1;
        end else begin
            return UNIT0;
        end
    endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Bundle of decode, execute-result and register-cell signals around regfile_wb_ctrl.
// The controller takes the slave view; the surrounding pipeline/cell array takes master.
interface regfile_wb_ctrl_if
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int LEN_REG = regfile_wb_ctrl_pkg::LEN_REG,
    parameter int NUM_REG = regfile_wb_ctrl_pkg::NUM_REG,
    parameter int IDX_W   = $clog2(NUM_REG)
);

    logic               rsv_valid_i;
    logic [IDX_W-1:0]   rsv_idx_i;
    logic               rsv_ready_o;

    logic               res0_valid_i;
    logic [IDX_W-1:0]   res0_idx_i;
    logic [LEN_REG-1:0] res0_data_i;
    logic               res0_ready_o;

    logic               res1_valid_i;
    logic [IDX_W-1:0]   res1_idx_i;
    logic [LEN_REG-1:0] res1_data_i;
    logic               res1_ready_o;

    logic [IDX_W-1:0]   rd_a_idx_i;
    logic [IDX_W-1:0]   rd_b_idx_i;
    logic               hazard_o;

    logic [NUM_REG-1:0] cell_reserve_i;
    logic [NUM_REG-1:0] w_reserve_o;
    logic [NUM_REG-1:0] wb_o;
    logic [LEN_REG-1:0] wb_data_o;

    modport slave (
        input  rsv_valid_i, rsv_idx_i,
        output rsv_ready_o,
        input  res0_valid_i, res0_idx_i, res0_data_i,
        output res0_ready_o,
        input  res1_valid_i, res1_idx_i, res1_data_i,
        output res1_ready_o,
        input  rd_a_idx_i, rd_b_idx_i,
        output hazard_o,
        input  cell_reserve_i,
        output w_reserve_o, wb_o, wb_data_o
    );

    modport master (
        output rsv_valid_i, rsv_idx_i,
        input  rsv_ready_o,
        output res0_valid_i, res0_idx_i, res0_data_i,
        input  res0_ready_o,
        output res1_valid_i, res1_idx_i, res1_data_i,
        input  res1_ready_o,
        output rd_a_idx_i, rd_b_idx_i,
        input  hazard_o,
        output cell_reserve_i,
        input  w_reserve_o, wb_o, wb_data_o
    );

endinterface

// File: rtl/regfile_wb_ctrl_wb_fifo.sv
// Synchronous result FIFO (index + data) for the writeback path.
// Only pointers and count are reset; stored entries are simply abandoned.
module wb_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-side controller: reservations, operand hazard, and
// round-robin result buffering into a one-per-cycle writeback. Option: WB_BYPASS_EN.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int LEN_REG    = regfile_wb_ctrl_pkg::LEN_REG,
    parameter int NUM_REG    = regfile_wb_ctrl_pkg::NUM_REG,
    parameter int IDX_W      = $clog2(NUM_REG),
    parameter int FIFO_DEPTH = regfile_wb_ctrl_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    regfile_wb_ctrl_if.slave  bus
);

    localparam int ENT_W = IDX_W + LEN_REG;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    function automatic logic [NUM_REG-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    logic               rsv_ok;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENT_W-1:0]   head;
    logic               pop;
    logic               accept;
    unit_t              last_grant;
    unit_t              pick;
    logic               gnt0;
    logic               gnt1;
    logic               any_grant;
    logic               bypass;
    logic               push;
    logic [IDX_W-1:0]   sel_idx;
    logic [LEN_REG-1:0] sel_data;

    // Reservation and hazard are purely combinational from the cells' state.
    assign rsv_ok          = bus.rsv_valid_i & ~bus.cell_reserve_i[bus.rsv_idx_i] & ~rst;
    assign bus.rsv_ready_o = rsv_ok;
    assign bus.w_reserve_o = rsv_ok ? onehot(bus.rsv_idx_i) : '0;
    assign bus.hazard_o    = bus.cell_reserve_i[bus.rd_a_idx_i] | bus.cell_reserve_i[bus.rd_b_idx_i];

    assign pop    = ~fifo_empty;
    assign accept = ~rst & (~fifo_full | pop);
    assign pick   = rr_pick(bus.res0_valid_i, bus.res1_valid_i, last_grant);

    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        sel_idx  = bus.res0_idx_i;
        sel_data = bus.res0_data_i;
        if (accept) begin
            gnt0 = bus.res0_valid_i & (pick == UNIT0);
            gnt1 = bus.res1_valid_i & (pick == UNIT1);
        end
        if (pick == UNIT1) begin
            sel_idx  = bus.res1_idx_i;
            sel_data = bus.res1_data_i;
        end
    end

    assign any_grant        = gnt0 | gnt1;
    assign bus.res0_ready_o = gnt0;
    assign bus.res1_ready_o = gnt1;

`ifdef WB_BYPASS_EN
    assign bypass = any_grant & fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign push = any_grant & ~bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= UNIT1;
        end else if (any_grant) begin
            last_grant <= pick;
        end
    end

    wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({sel_idx, sel_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Queued results always drain ahead of a bypassed one to keep order.
    always_comb begin
        bus.wb_o      = '0;
        bus.wb_data_o = '0;
        if (!rst) begin
            if (!fifo_empty) begin
                bus.wb_o      = onehot(head[ENT_W-1 -: IDX_W]);
                bus.wb_data_o = head[LEN_REG-1:0];
            end else if (bypass) begin
                bus.wb_o      = onehot(sel_idx);
                bus.wb_data_o = sel_data;
            end
        end
    end

    count_bound: assert property (@(posedge clk) fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed steps then random traffic
// compared against a queue-based reference model.
module tb_regfile_wb_ctrl;
    import regfile_wb_ctrl_pkg::*;

    localparam int LW = regfile_wb_ctrl_pkg::LEN_REG;
    localparam int NR = regfile_wb_ctrl_pkg::NUM_REG;
    localparam int IW = $clog2(NR);
    localparam int FD = regfile_wb_ctrl_pkg::FIFO_DEPTH;

    typedef struct {
        logic [IW-1:0] idx;
        logic [LW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    ent_t q[$];
    int   m_last = 1;

    regfile_wb_ctrl_if #(.LEN_REG(LW), .NUM_REG(NR), .IDX_W(IW)) bus ();

    regfile_wb_ctrl #(.LEN_REG(LW), .NUM_REG(NR), .IDX_W(IW), .FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic          e_rr;
        logic [NR-1:0] e_wr;
        logic          e_hz;
        logic          acc;
        int            g;
        logic          byp;
        logic [NR-1:0] e_wb;
        logic [LW-1:0] e_wd;
        ent_t          sel;
        #2;
        e_rr = bus.rsv_valid_i & ~bus.cell_reserve_i[bus.rsv_idx_i] & ~rst;
        e_wr = e_rr ? (NR'(1) << bus.rsv_idx_i) : '0;
        e_hz = bus.cell_reserve_i[bus.rd_a_idx_i] | bus.cell_reserve_i[bus.rd_b_idx_i];
        acc  = !rst && (q.size() < FD || q.size() > 0);
        g    = -1;
        if (acc) begin
            if (bus.res0_valid_i && bus.res1_valid_i) g = (m_last == 1) ? 0 : 1;
            else if (bus.res0_valid_i) g = 0;
            else if (bus.res1_valid_i) g = 1;
        end
        sel.idx  = (g == 1) ? bus.res1_idx_i  : bus.res0_idx_i;
        sel.data = (g == 1) ? bus.res1_data_i : bus.res0_data_i;
`ifdef WB_BYPASS_EN
        byp = (g >= 0) && (q.size() == 0);
`else
        byp = 1'b0;
`endif
        e_wb = '0;
        e_wd = '0;
        if (!rst) begin
            if (q.size() > 0) begin
                e_wb = NR'(1) << q[0].idx;
                e_wd = q[0].data;
            end else if (byp) begin
                e_wb = NR'(1) << sel.idx;
                e_wd = sel.data;
            end
        end
        check("rsv_ready", 64'(bus.rsv_ready_o), 64'(e_rr));
        check("w_reserve", 64'(bus.w_reserve_o), 64'(e_wr));
        check("hazard",    64'(bus.hazard_o),    64'(e_hz));
        check("res0_ready", 64'(bus.res0_ready_o), 64'(g == 0));
        check("res1_ready", 64'(bus.res1_ready_o), 64'(g == 1));
        check("wb_o",      64'(bus.wb_o),      64'(e_wb));
        check("wb_data",   64'(bus.wb_data_o), 64'(e_wd));
        check("count",     64'(dut.u_fifo.count), 64'(q.size()));
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_last = 1;
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (g >= 0 && !byp) q.push_back(sel);
            if (g >= 0) m_last = g;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.rsv_valid_i    = 1'b0;
        bus.rsv_idx_i      = '0;
        bus.res0_valid_i   = 1'b0;
        bus.res0_idx_i     = '0;
        bus.res0_data_i    = '0;
        bus.res1_valid_i   = 1'b0;
        bus.res1_idx_i     = '0;
        bus.res1_data_i    = '0;
        bus.rd_a_idx_i     = '0;
        bus.rd_b_idx_i     = '0;
        bus.cell_reserve_i = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        bus.rsv_valid_i  = 1'b1;
        bus.res0_valid_i = 1'b1;
        bus.res1_valid_i = 1'b1;
        cycle();
        cycle();
        idle_inputs();
        rst = 1'b0;
        cycle();

        // Reserve r3, then retry while the cell shows it reserved.
        bus.rsv_valid_i = 1'b1;
        bus.rsv_idx_i   = IW'(3);
        #2;
        check("rsv_r3_strobe", 64'(bus.w_reserve_o), 64'h0008);
        #0 cycle();
        bus.cell_reserve_i = NR'(1) << 3;
        cycle();
        bus.rsv_valid_i = 1'b0;

        // Hazard on r7 appears and clears combinationally.
        bus.rd_a_idx_i     = IW'(7);
        bus.rd_b_idx_i     = IW'(0);
        bus.cell_reserve_i = NR'(1) << 7;
        cycle();
        bus.cell_reserve_i = '0;
        cycle();

        // Both units contending for six cycles.
        bus.res0_valid_i = 1'b1;
        bus.res0_idx_i   = IW'(1);
        bus.res0_data_i  = LW'(32'hAAAA);
        bus.res1_valid_i = 1'b1;
        bus.res1_idx_i   = IW'(2);
        bus.res1_data_i  = LW'(32'h5555);
        for (int i = 0; i < FD + 2; i++) cycle();
        idle_inputs();
        cycle();
        cycle();

        // Two back-to-back writes to r5 drain in order.
        bus.res0_valid_i = 1'b1;
        bus.res0_idx_i   = IW'(5);
        bus.res0_data_i  = LW'(1);
        cycle();
        bus.res0_data_i  = LW'(2);
        cycle();
        bus.res0_valid_i = 1'b0;
        cycle();
        cycle();

        // Reset in the middle of a stream, then a fresh tie.
        bus.res0_valid_i = 1'b1;
        bus.res1_valid_i = 1'b1;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.res0_data_i = LW'(32'h1234);
        bus.res1_data_i = LW'(32'h9876);
        #2;
        check("tie_after_rst_u0", 64'(bus.res0_ready_o), 64'd1);
        #0 cycle();
        idle_inputs();
        cycle();
        cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst                = ($urandom_range(0, 39) == 0);
            bus.rsv_valid_i    = $urandom_range(0, 1) == 1;
            bus.rsv_idx_i      = IW'($urandom);
            bus.cell_reserve_i = NR'($urandom);
            bus.rd_a_idx_i     = IW'($urandom);
            bus.rd_b_idx_i     = IW'($urandom);
            bus.res0_valid_i   = $urandom_range(0, 2) != 0;
            bus.res0_idx_i     = IW'($urandom);
            bus.res0_data_i    = LW'($urandom);
            bus.res1_valid_i   = $urandom_range(0, 2) != 0;
            bus.res1_idx_i     = IW'($urandom);
            bus.res1_data_i    = LW'($urandom);
            cycle();
        end
        rst = 1'b0;
        idle_inputs();
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
